// File: rtl/rggen_axi4lite_slice_if.sv
// AXI4-Lite interface shared by the rggen bridge and the register slice.
interface rggen_axi4lite_if #(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned BUS_WIDTH     = 32
);
    logic                     awvalid;
    logic                     awready;
    logic [ADDRESS_WIDTH-1:0] awaddr;
    logic [2:0]               awprot;
    logic                     wvalid;
    logic                     wready;
    logic [BUS_WIDTH-1:0]     wdata;
    logic [BUS_WIDTH/8-1:0]   wstrb;
    logic                     bvalid;
    logic                     bready;
    logic [1:0]               bresp;
    logic                     arvalid;
    logic                     arready;
    logic [ADDRESS_WIDTH-1:0] araddr;
    logic [2:0]               arprot;
    logic                     rvalid;
    logic                     rready;
    logic [BUS_WIDTH-1:0]     rdata;
    logic [1:0]               rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/rggen_axi4lite_slice.sv
// AXI4-Lite register slice: 2-entry skid buffer on AW, W, AR (and B, R when
// RGGEN_AXI4LITE_SLICE_RESP_EN is defined).
module rggen_axi4lite_slice #(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned BUS_WIDTH     = 32
) (
    input logic                  i_clk,
    input logic                  i_rst,
    rggen_axi4lite_if.slave      slave_if,
    rggen_axi4lite_if.master     master_if
);
    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    // Channel index: 0=AW, 1=W, 2=AR, 3=B, 4=R
    function automatic int unsigned ch_width(int unsigned c);
        case (c)
            0, 2:    return ADDRESS_WIDTH + 3;
            1:       return BUS_WIDTH + BUS_WIDTH / 8;
            3:       return 2;
            default: return BUS_WIDTH + 2;
        endcase
    endfunction

`ifdef RGGEN_AXI4LITE_SLICE_RESP_EN
    localparam int unsigned NUM_CH = 5;
`else
    localparam int unsigned NUM_CH = 3;

    assign slave_if.bvalid  = master_if.bvalid;
    assign slave_if.bresp   = master_if.bresp;
    assign master_if.bready = slave_if.bready;
    assign slave_if.rvalid  = master_if.rvalid;
    assign slave_if.rdata   = master_if.rdata;
    assign slave_if.rresp   = master_if.rresp;
    assign master_if.rready = slave_if.rready;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam int unsigned W = ch_width(c);

        state_e         state;
        logic           up_valid;
        logic           up_ready_q;
        logic [W-1:0]   up_data;
        logic           dn_valid_q;
        logic           dn_ready;
        logic [W-1:0]   main_q;
        logic [W-1:0]   skid_q;
        logic           up_fire;
        logic           dn_fire;

        assign up_fire = up_valid & up_ready_q;
        assign dn_fire = dn_valid_q & dn_ready;

        if (c == 0) begin : g_aw
            assign up_valid                             = slave_if.awvalid;
            assign up_data                              = {slave_if.awaddr, slave_if.awprot};
            assign slave_if.awready                     = up_ready_q;
            assign dn_ready                             = master_if.awready;
            assign master_if.awvalid                    = dn_valid_q;
            assign {master_if.awaddr, master_if.awprot} = main_q;
        end else if (c == 1) begin : g_w
            assign up_valid                           = slave_if.wvalid;
            assign up_data                            = {slave_if.wdata, slave_if.wstrb};
            assign slave_if.wready                    = up_ready_q;
            assign dn_ready                           = master_if.wready;
            assign master_if.wvalid                   = dn_valid_q;
            assign {master_if.wdata, master_if.wstrb} = main_q;
        end else if (c == 2) begin : g_ar
            assign up_valid                             = slave_if.arvalid;
            assign up_data                              = {slave_if.araddr, slave_if.arprot};
            assign slave_if.arready                     = up_ready_q;
            assign dn_ready                             = master_if.arready;
            assign master_if.arvalid                    = dn_valid_q;
            assign {master_if.araddr, master_if.arprot} = main_q;
        end else if (c == 3) begin : g_b
            assign up_valid         = master_if.bvalid;
            assign up_data          = master_if.bresp;
            assign master_if.bready = up_ready_q;
            assign dn_ready         = slave_if.bready;
            assign slave_if.bvalid  = dn_valid_q;
            assign slave_if.bresp   = main_q;
        end else begin : g_r
            assign up_valid                         = master_if.rvalid;
            assign up_data                          = {master_if.rdata, master_if.rresp};
            assign master_if.rready                 = up_ready_q;
            assign dn_ready                         = slave_if.rready;
            assign slave_if.rvalid                  = dn_valid_q;
            assign {slave_if.rdata, slave_if.rresp} = main_q;
        end

        // Main reg is held while stalled; a new beat lands in the skid reg instead.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                state      <= StEmpty;
                up_ready_q <= 1'b0;
                dn_valid_q <= 1'b0;
                main_q     <= '0;
                skid_q     <= '0;
            end else begin
                case (state)
                    StEmpty: begin
                        up_ready_q <= 1'b1;
                        if (up_fire) begin
                            main_q     <= up_data;
                            dn_valid_q <= 1'b1;
                            state      <= StOne;
                        end
                    end
                    StOne: begin
                        if (up_fire && dn_fire) begin
                            main_q <= up_data;
                        end else if (up_fire) begin
                            skid_q     <= up_data;
                            up_ready_q <= 1'b0;
                            state      <= StFull;
                        end else if (dn_fire) begin
                            dn_valid_q <= 1'b0;
                            state      <= StEmpty;
                        end
                    end
                    StFull: begin
                        if (dn_fire) begin
                            main_q     <= skid_q;
                            up_ready_q <= 1'b1;
                            state      <= StOne;
                        end
                    end
                    default: begin
                        state      <= StEmpty;
                        up_ready_q <= 1'b0;
                        dn_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rggen_axi4lite_slice.sv
// Self-checking bench for rggen_axi4lite_slice: AR vector table, AW/W/AR
// scoreboards, and hand-written write, skew and reset sequences.
module tb_rggen_axi4lite_slice;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rggen_axi4lite_if #(.ADDRESS_WIDTH(16), .BUS_WIDTH(32)) s_if ();
    rggen_axi4lite_if #(.ADDRESS_WIDTH(16), .BUS_WIDTH(32)) m_if ();

    rggen_axi4lite_slice #(
        .ADDRESS_WIDTH (16),
        .BUS_WIDTH     (32)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .slave_if  (s_if),
        .master_if (m_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Scoreboards: pushed on upstream handshake, popped on downstream handshake.
    logic [63:0] aw_q[$];
    logic [63:0] w_q[$];
    logic [63:0] ar_q[$];

    task automatic sb_pop(input string name, inout logic [63:0] q[$], input logic [63:0] got);
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0h required no transfer", name, got);
        end else begin
            check(name, got, q.pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            aw_q.delete();
            w_q.delete();
            ar_q.delete();
        end else begin
            if (s_if.awvalid && s_if.awready) aw_q.push_back(64'({s_if.awaddr, s_if.awprot}));
            if (s_if.wvalid && s_if.wready) w_q.push_back(64'({s_if.wdata, s_if.wstrb}));
            if (s_if.arvalid && s_if.arready) ar_q.push_back(64'({s_if.araddr, s_if.arprot}));
            if (m_if.awvalid && m_if.awready)
                sb_pop("aw_order", aw_q, 64'({m_if.awaddr, m_if.awprot}));
            if (m_if.wvalid && m_if.wready)
                sb_pop("w_order", w_q, 64'({m_if.wdata, m_if.wstrb}));
            if (m_if.arvalid && m_if.arready)
                sb_pop("ar_order", ar_q, 64'({m_if.araddr, m_if.arprot}));
        end
    end

    // Downstream returns one B beat; the response must reach the bridge side.
    task automatic do_b(input logic [1:0] resp);
        bit seen;
        bit hs_m;
        seen = 1'b0;
        @(posedge clk);
        #1;
        m_if.bvalid = 1'b1;
        m_if.bresp  = resp;
        s_if.bready = 1'b1;
        for (int i = 0; i < 10 && !(seen && !m_if.bvalid); i++) begin
            @(negedge clk);
            hs_m = m_if.bvalid && m_if.bready;
            if (s_if.bvalid && s_if.bready && !seen) begin
                check("bresp", 64'(s_if.bresp), 64'(resp));
                seen = 1'b1;
            end
            @(posedge clk);
            #1;
            if (hs_m) m_if.bvalid = 1'b0;
        end
        m_if.bvalid = 1'b0;
        if (!seen) check("bvalid_timeout", 64'(seen), 64'(1));
    endtask

    typedef struct packed {
        logic        vld;
        logic [15:0] addr;
        logic        dn_rdy;
        logic        exp_up_rdy;
        logic        exp_dn_vld;
        logic [15:0] exp_dn_addr;
    } ar_vec_t;

    localparam int NV = 19;
    ar_vec_t vec[NV];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 0-9: 8 back-to-back reads; 10-18: stream with a 3-cycle arready stall.
        vec = '{
            '{1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000},
            '{1'b1, 16'h0004, 1'b1, 1'b1, 1'b1, 16'h0000},
            '{1'b1, 16'h0008, 1'b1, 1'b1, 1'b1, 16'h0004},
            '{1'b1, 16'h000C, 1'b1, 1'b1, 1'b1, 16'h0008},
            '{1'b1, 16'h0010, 1'b1, 1'b1, 1'b1, 16'h000C},
            '{1'b1, 16'h0014, 1'b1, 1'b1, 1'b1, 16'h0010},
            '{1'b1, 16'h0018, 1'b1, 1'b1, 1'b1, 16'h0014},
            '{1'b1, 16'h001C, 1'b1, 1'b1, 1'b1, 16'h0018},
            '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h001C},
            '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000},
            '{1'b1, 16'h0100, 1'b1, 1'b1, 1'b0, 16'h0000},
            '{1'b1, 16'h0104, 1'b0, 1'b1, 1'b1, 16'h0100},
            '{1'b1, 16'h0108, 1'b0, 1'b0, 1'b1, 16'h0100},
            '{1'b1, 16'h0108, 1'b0, 1'b0, 1'b1, 16'h0100},
            '{1'b1, 16'h0108, 1'b1, 1'b0, 1'b1, 16'h0100},
            '{1'b1, 16'h0108, 1'b1, 1'b1, 1'b1, 16'h0104},
            '{1'b1, 16'h010C, 1'b1, 1'b1, 1'b1, 16'h0108},
            '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h010C},
            '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000}
        };
        checks = 0;
        errors = 0;

        rst = 1'b1;
        s_if.awvalid = 1'b1; s_if.awaddr = 16'h0; s_if.awprot = 3'b0;
        s_if.wvalid  = 1'b0; s_if.wdata  = 32'h0; s_if.wstrb  = 4'h0;
        s_if.arvalid = 1'b0; s_if.araddr = 16'h0; s_if.arprot = 3'b0;
        s_if.bready  = 1'b0; s_if.rready = 1'b0;
        m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.arready = 1'b0;
        m_if.bvalid  = 1'b0; m_if.bresp  = 2'b0;
        m_if.rvalid  = 1'b0; m_if.rdata  = 32'h0; m_if.rresp = 2'b0;

        // Reset with awvalid held high
        repeat (3) @(negedge clk);
        check("rst_m_awvalid", 64'(m_if.awvalid), 64'(0));
        check("rst_m_wvalid", 64'(m_if.wvalid), 64'(0));
        check("rst_m_arvalid", 64'(m_if.arvalid), 64'(0));
        check("rst_s_awready", 64'(s_if.awready), 64'(0));
        check("rst_m_awaddr", 64'(m_if.awaddr), 64'(0));
        rst = 1'b0;
        check("rel_s_awready_before_edge", 64'(s_if.awready), 64'(0));
        @(posedge clk);
        #1;
        s_if.awvalid = 1'b0;
        @(negedge clk);
        check("rel_s_awready", 64'(s_if.awready), 64'(1));
        check("rel_s_arready", 64'(s_if.arready), 64'(1));
        check("rel_m_awvalid", 64'(m_if.awvalid), 64'(0));

        // Single write, AW and W together
        @(posedge clk);
        #1;
        m_if.awready = 1'b1; m_if.wready = 1'b1; m_if.arready = 1'b1;
        s_if.bready = 1'b1; s_if.rready = 1'b1;
        s_if.awvalid = 1'b1; s_if.awaddr = 16'h0010; s_if.awprot = 3'b000;
        s_if.wvalid = 1'b1; s_if.wdata = 32'hDEAD_BEEF; s_if.wstrb = 4'hF;
        @(negedge clk);
        check("wr_m_awvalid_t0", 64'(m_if.awvalid), 64'(0));
        @(posedge clk);
        #1;
        s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
        @(negedge clk);
        check("wr_m_awvalid", 64'(m_if.awvalid), 64'(1));
        check("wr_m_wvalid", 64'(m_if.wvalid), 64'(1));
        check("wr_m_awaddr", 64'(m_if.awaddr), 64'h0010);
        check("wr_m_wdata", 64'(m_if.wdata), 64'hDEAD_BEEF);
        check("wr_m_wstrb", 64'(m_if.wstrb), 64'hF);
        do_b(2'b00);

        // AR stream table
        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            s_if.arvalid = vec[i].vld;
            s_if.araddr  = vec[i].addr;
            s_if.arprot  = vec[i].addr[4:2];
            m_if.arready = vec[i].dn_rdy;
            @(negedge clk);
            check($sformatf("ar_s_arready[%0d]", i), 64'(s_if.arready), 64'(vec[i].exp_up_rdy));
            check($sformatf("ar_m_arvalid[%0d]", i), 64'(m_if.arvalid), 64'(vec[i].exp_dn_vld));
            if (vec[i].exp_dn_vld) begin
                check($sformatf("ar_m_araddr[%0d]", i), 64'(m_if.araddr),
                      64'(vec[i].exp_dn_addr));
                check($sformatf("ar_m_arprot[%0d]", i), 64'(m_if.arprot),
                      64'(vec[i].exp_dn_addr[4:2]));
            end
        end

        // W presented 4 cycles ahead of AW, SLVERR response
        @(posedge clk);
        #1;
        m_if.arready = 1'b1;
        s_if.wvalid = 1'b1; s_if.wdata = 32'hCAFE_F00D; s_if.wstrb = 4'h5;
        @(posedge clk);
        #1;
        s_if.wvalid = 1'b0;
        @(negedge clk);
        check("skew_m_wvalid", 64'(m_if.wvalid), 64'(1));
        check("skew_m_wdata", 64'(m_if.wdata), 64'hCAFE_F00D);
        check("skew_m_awvalid", 64'(m_if.awvalid), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        s_if.awvalid = 1'b1; s_if.awaddr = 16'h0020; s_if.awprot = 3'b001;
        @(posedge clk);
        #1;
        s_if.awvalid = 1'b0;
        @(negedge clk);
        check("skew_m_awvalid_late", 64'(m_if.awvalid), 64'(1));
        check("skew_m_awaddr", 64'(m_if.awaddr), 64'h0020);
        do_b(2'b10);

        @(negedge clk);
        check("aw_drained", 64'(aw_q.size()), 64'(0));
        check("w_drained", 64'(w_q.size()), 64'(0));
        check("ar_drained", 64'(ar_q.size()), 64'(0));

        // Fill AW and W to FULL, then reset mid-cycle
        @(posedge clk);
        #1;
        m_if.awready = 1'b0; m_if.wready = 1'b0;
        s_if.awvalid = 1'b1; s_if.awaddr = 16'h0030; s_if.awprot = 3'b0;
        s_if.wvalid = 1'b1; s_if.wdata = 32'h1111_1111; s_if.wstrb = 4'hF;
        @(posedge clk);
        #1;
        s_if.awaddr = 16'h0034; s_if.wdata = 32'h2222_2222;
        @(posedge clk);
        #1;
        s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
        @(negedge clk);
        check("full_s_awready", 64'(s_if.awready), 64'(0));
        check("full_s_wready", 64'(s_if.wready), 64'(0));
        check("full_m_awaddr", 64'(m_if.awaddr), 64'h0030);
        #2;
        rst = 1'b1;
        #1;
        check("arst_m_awvalid", 64'(m_if.awvalid), 64'(0));
        check("arst_m_wvalid", 64'(m_if.wvalid), 64'(0));
        check("arst_s_awready", 64'(s_if.awready), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_if.awready = 1'b1; m_if.wready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_m_awvalid[%0d]", i), 64'(m_if.awvalid), 64'(0));
            check($sformatf("post_rst_m_wvalid[%0d]", i), 64'(m_if.wvalid), 64'(0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
